// File: rtl/rrv64_top_param_pkg.sv
// ---------------------------------------------------------------------------
// rrv64_top_param_pkg
//   Shared definitions for the rrv64 uncore AXI helpers:
//     - AXI burst-type and response-code constants
//     - rrv64_split_state_e : AR-side state of the read-burst splitter
//     - rrv64_split_len_legal : legality check for the sub-burst length
// ---------------------------------------------------------------------------
package rrv64_top_param_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2
  } rrv64_split_state_e;

  // Sub-burst length must be a power of two that fits a 4-bit arlen.
  function automatic bit rrv64_split_len_legal(input int len);
    return (len == 2) || (len == 4) || (len == 8) || (len == 16);
  endfunction

endpackage

// File: rtl/rrv64_axi_rd_burst_split.sv
// ---------------------------------------------------------------------------
// rrv64_axi_rd_burst_split
//   Splits one AXI4 read burst (8-bit arlen, up to 256 beats) into a train of
//   sub-bursts of at most MAX_SUB_LEN beats for a 4-bit-arlen slave, and
//   merges the returned R beats back into one parent burst with a single
//   rlast. One parent burst is in flight at a time; its sub-ARs issue
//   back-to-back. The R path is a zero-latency combinational pass-through.
//
// Parameters
//   ADDR_W      address width
//   ID_W        ID width (passed through)
//   DATA_W      R data width
//   MAX_SUB_LEN beats per sub-burst: 2, 4, 8 or 16
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   s_ar*  (valid/ready/addr/id/len/size/burst)   parent AR from master
//   m_ar*  (valid/ready/addr/id/len/size/burst)   sub-burst AR to slave
//   m_r*   (valid/ready/data/id/resp/last)        sub-burst R from slave
//   s_r*   (valid/ready/data/id/resp/last)        merged R to master
//   busy                             a parent burst is in flight
//
// Build option
//   RRV64_AXI_SPLIT_STICKY_ERR_EN : once a beat of the parent returns SLVERR
//   or DECERR, all later beats of that parent report the same code (DECERR
//   wins over SLVERR). Undefined: rresp is forwarded per beat.
//
// AR FSM states
//   state  | meaning
//   IDLE   | s_arready=1, waiting for a parent AR
//   ISSUE  | presenting sub-ARs on m_ar*, one per m_arready
//   WAIT_R | all sub-ARs issued, waiting for the final merged beat
// ---------------------------------------------------------------------------
module rrv64_axi_rd_burst_split
  import rrv64_top_param_pkg::*;
#(
  parameter int ADDR_W      = 40,
  parameter int ID_W        = 4,
  parameter int DATA_W      = 64,
  parameter int MAX_SUB_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic [ID_W-1:0]   s_arid,
  input  logic [7:0]        s_arlen,
  input  logic [2:0]        s_arsize,
  input  logic [1:0]        s_arburst,

  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W-1:0]   m_arid,
  output logic [3:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,

  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,

  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [ID_W-1:0]   s_rid,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,

  output logic              busy
);

  generate
    if (!rrv64_split_len_legal(MAX_SUB_LEN)) begin : g_bad_sub_len
      $error("rrv64_axi_rd_burst_split: MAX_SUB_LEN must be 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [8:0] SUB_MAX = 9'(MAX_SUB_LEN);

  rrv64_split_state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [8:0]        total_q;
  logic [8:0]        ar_left_q, ar_left_d;
  logic [8:0]        r_cnt_q;

  logic [8:0]        sub_len;
  logic [ADDR_W-1:0] addr_align;
  logic [ADDR_W-1:0] addr_incr;
  logic              s_ar_hs;
  logic              r_hs;
  logic              last_beat;

  // Framing comes from our own beat count, not the slave's per-sub-burst rlast.
  logic              unused_m_rlast;
  assign unused_m_rlast = m_rlast;

  assign s_ar_hs = s_arvalid & s_arready;
  assign r_hs    = m_rvalid & s_rready;

  assign sub_len = (ar_left_q > SUB_MAX) ? SUB_MAX : ar_left_q;

  // INCR continuation: the first sub-AR keeps the (possibly unaligned)
  // parent address, later ones start on a transfer-size boundary. The sum
  // wraps naturally at ADDR_W bits.
  assign addr_align = addr_q & ~((ADDR_W'(1) << size_q) - ADDR_W'(1));
  assign addr_incr  = addr_align + (ADDR_W'(sub_len) << size_q);

  assign last_beat = (r_cnt_q == (total_q - 9'd1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ar_left_d = ar_left_q;
    s_arready = 1'b0;
    m_arvalid = 1'b0;
    case (state_q)
      IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) state_d = ISSUE;
      end
      ISSUE: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          ar_left_d = ar_left_q - sub_len;
          if (burst_q == AXI_BURST_INCR) addr_d = addr_incr;
          if (ar_left_d == 9'd0) state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        if (r_hs && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      total_q   <= '0;
      ar_left_q <= '0;
      r_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (s_ar_hs) begin
        addr_q    <= s_araddr;
        id_q      <= s_arid;
        size_q    <= s_arsize;
        burst_q   <= s_arburst;
        total_q   <= {1'b0, s_arlen} + 9'd1;
        ar_left_q <= {1'b0, s_arlen} + 9'd1;
        r_cnt_q   <= '0;
      end else begin
        addr_q    <= addr_d;
        ar_left_q <= ar_left_d;
        if (r_hs) r_cnt_q <= r_cnt_q + 9'd1;
      end
    end
  end

  assign m_araddr  = addr_q;
  assign m_arid    = id_q;
  assign m_arsize  = size_q;
  assign m_arburst = burst_q;
  assign m_arlen   = (state_q == ISSUE) ? 4'(sub_len - 9'd1) : 4'd0;

  assign busy = (state_q != IDLE);

  assign s_rvalid = m_rvalid;
  assign m_rready = s_rready;
  assign s_rdata  = m_rdata;
  assign s_rid    = m_rid;
  assign s_rlast  = last_beat;

`ifdef RRV64_AXI_SPLIT_STICKY_ERR_EN
  logic [1:0] sticky_q;

  // The current beat already sees a latched error, and DECERR from either
  // source dominates SLVERR.
  always_comb begin
    if ((m_rresp == AXI_RESP_DECERR) || (sticky_q == AXI_RESP_DECERR))
      s_rresp = AXI_RESP_DECERR;
    else if ((m_rresp == AXI_RESP_SLVERR) || (sticky_q == AXI_RESP_SLVERR))
      s_rresp = AXI_RESP_SLVERR;
    else
      s_rresp = m_rresp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= AXI_RESP_OKAY;
    end else if (state_q == IDLE) begin
      sticky_q <= AXI_RESP_OKAY;
    end else if (r_hs && s_rresp[1]) begin
      sticky_q <= s_rresp;
    end
  end
`else
  assign s_rresp = m_rresp;
`endif

  // A WRAP burst is forwarded as a single sub-burst, so it must fit in one.
  a_wrap_fits : assert property (@(posedge clk) disable iff (!rst_n)
    (s_ar_hs && (s_arburst == AXI_BURST_WRAP)) |-> ({1'b0, s_arlen} < SUB_MAX));

endmodule

// File: tb/tb_rrv64_axi_rd_burst_split.sv
module tb_rrv64_axi_rd_burst_split;

  localparam int ADDR_W      = 40;
  localparam int ID_W        = 4;
  localparam int DATA_W      = 64;
  localparam int MAX_SUB_LEN = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_arvalid, s_arready;
  logic [ADDR_W-1:0] s_araddr;
  logic [ID_W-1:0]   s_arid;
  logic [7:0]        s_arlen;
  logic [2:0]        s_arsize;
  logic [1:0]        s_arburst;
  logic              m_arvalid, m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [ID_W-1:0]   m_arid;
  logic [3:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_rvalid, m_rready;
  logic [DATA_W-1:0] m_rdata;
  logic [ID_W-1:0]   m_rid;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              s_rvalid, s_rready;
  logic [DATA_W-1:0] s_rdata;
  logic [ID_W-1:0]   s_rid;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              busy;

  always #5 clk = ~clk;

  rrv64_axi_rd_burst_split #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W), .MAX_SUB_LEN(MAX_SUB_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .busy(busy)
  );

  typedef struct packed {
    logic [39:0] addr;
    logic [3:0]  len;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    logic [1:0]  resp;
    logic        last;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  tests = 0;
  int  fails = 0;

  // slave-model controls (written by the main sequence)
  int          stall_left    = 0;
  bit          r_hold        = 1'b0;
  bit          rready_toggle = 1'b0;
  int          err1 = 0;
  int          err2 = 0;
  logic [15:0] tag  = 16'h0;

  // slave-model state
  int          pending = 0;
  int          beat_no = 0;
  logic [3:0]  cur_id  = 4'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_resp(input int k, input int e1, input int e2);
`ifdef RRV64_AXI_SPLIT_STICKY_ERR_EN
    if (e2 > 0 && k >= e2) return 2'd3;
    if (e1 > 0 && k >= e1) return 2'd2;
    return 2'd0;
`else
    if (k == e2) return 2'd3;
    if (k == e1) return 2'd2;
    return 2'd0;
`endif
  endfunction

  task automatic push_ar(input logic [39:0] a, input logic [3:0] len, input logic [3:0] id,
                         input logic [2:0] size, input logic [1:0] burst);
    ar_t e;
    e.addr = a; e.len = len; e.id = id; e.size = size; e.burst = burst;
    ar_q.push_back(e);
  endtask

  task automatic push_r(input logic [15:0] t, input logic [3:0] id, input int total,
                        input int e1, input int e2);
    r_t e;
    for (int k = 1; k <= total; k++) begin
      e.data = {16'hD00D, t, 32'(k)};
      e.id   = id;
      e.resp = exp_resp(k, e1, e2);
      e.last = (k == total);
      r_q.push_back(e);
    end
  endtask

  // Slave: counts sub-AR beats owed, returns them in order, numbers beats
  // within the parent burst so the data encodes the beat index.
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rid = '0;
    m_rresp = 2'd0; m_rlast = 1'b0; s_rready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending = 0;
        beat_no = 0;
      end else begin
        if (s_arvalid && s_arready) beat_no = 0;
        if (m_arvalid && m_arready) begin
          pending += int'(m_arlen) + 1;
          cur_id = m_arid;
        end
        if (m_arvalid && !m_arready && stall_left > 0) stall_left--;
        if (m_rvalid && m_rready) begin
          pending--;
          beat_no++;
        end
      end
      @(posedge clk);
      #1;
      m_arready = (stall_left == 0);
      s_rready  = rready_toggle ? ~s_rready : 1'b1;
      m_rvalid  = rst_n && !r_hold && (pending > 0);
      m_rdata   = {16'hD00D, tag, 32'(beat_no + 1)};
      m_rid     = cur_id;
      m_rresp   = (beat_no + 1 == err1) ? 2'd2 : (beat_no + 1 == err2) ? 2'd3 : 2'd0;
      m_rlast   = (pending == 1);
    end
  end

  // Monitor / scoreboard
  initial begin
    ar_t cur_ar, exp_ar, held_ar;
    r_t  exp_r;
    bit  held_valid = 1'b0;
    bit  after_last = 1'b0;
    bit  after_sar  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_valid = 1'b0; after_last = 1'b0; after_sar = 1'b0;
        continue;
      end
      cur_ar.addr = m_araddr; cur_ar.len = m_arlen; cur_ar.id = m_arid;
      cur_ar.size = m_arsize; cur_ar.burst = m_arburst;
      check("s_rvalid_passthru", 64'(s_rvalid), 64'(m_rvalid));
      if (after_sar) check("first_sub_ar_latency", 64'(m_arvalid), 64'd1);
      if (after_last) begin
        check("s_arready_after_last", 64'(s_arready), 64'd1);
        check("busy_after_last", 64'(busy), 64'd0);
      end
      if (held_valid) begin
        check("ar_held_valid", 64'(m_arvalid), 64'd1);
        check("ar_held_fields", 64'(cur_ar), 64'(held_ar));
      end
      after_sar  = s_arvalid && s_arready;
      after_last = 1'b0;
      held_valid = 1'b0;
      if (m_arvalid && m_arready) begin
        if (ar_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_sub_ar: got 0x%0h expected none", cur_ar);
        end else begin
          exp_ar = ar_q.pop_front();
          check("sub_ar{addr,len,id,size,burst}", 64'(cur_ar), 64'(exp_ar));
        end
      end else if (m_arvalid) begin
        held_valid = 1'b1;
        held_ar    = cur_ar;
      end
      if (s_rvalid && s_rready) begin
        if (r_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_r_beat: got data 0x%0h expected none", s_rdata);
        end else begin
          exp_r = r_q.pop_front();
          check("r_data", s_rdata, exp_r.data);
          check("r_id", 64'(s_rid), 64'(exp_r.id));
          check("r_resp", 64'(s_rresp), 64'(exp_r.resp));
          check("r_last", 64'(s_rlast), 64'(exp_r.last));
        end
        if (s_rlast) after_last = 1'b1;
      end
    end
  end

  task automatic send_ar(input logic [39:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cyc;
    @(posedge clk);
    #1;
    s_arvalid = 1'b1; s_araddr = a; s_arid = id; s_arlen = len;
    s_arsize = size; s_arburst = burst;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (s_arready) break;
      cyc++;
      if (cyc > 200) begin
        tests++; fails++;
        $display("FAIL parent_ar_timeout: s_arready stuck at 0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (ar_q.size() == 0 && r_q.size() == 0 && !busy) break;
      cyc++;
      if (cyc > 2000) begin
        tests++; fails++;
        $display("FAIL %s_timeout: ar left %0d, r left %0d, busy %0d, expected 0/0/0",
                 name, ar_q.size(), r_q.size(), busy);
        ar_q.delete();
        r_q.delete();
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input string name, input logic [39:0] a, input logic [3:0] id,
                     input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                     input logic [15:0] t, input int e1, input int e2);
    tag = t; err1 = e1; err2 = e2;
    push_r(t, id, int'(len) + 1, e1, e2);
    send_ar(a, id, len, size, burst);
    wait_idle(name);
    err1 = 0; err2 = 0;
  endtask

  initial begin
    int cyc;
    s_arvalid = 1'b0; s_araddr = '0; s_arid = '0; s_arlen = '0;
    s_arsize = '0; s_arburst = '0;
    repeat (2) @(negedge clk);
    check("rst_s_arready", 64'(s_arready), 64'd1);
    check("rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_rvalid", 64'(s_rvalid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // INCR 40 beats, size 8B
    push_ar(40'h10_00, 4'd15, 4'd1, 3'd3, 2'b01);
    push_ar(40'h10_80, 4'd15, 4'd1, 3'd3, 2'b01);
    push_ar(40'h11_00, 4'd7,  4'd1, 3'd3, 2'b01);
    run("incr40", 40'h1000, 4'd1, 8'd39, 3'd3, 2'b01, 16'h0001, 0, 0);

    // FIXED 21 beats
    push_ar(40'h2000, 4'd15, 4'd2, 3'd3, 2'b00);
    push_ar(40'h2000, 4'd4,  4'd2, 3'd3, 2'b00);
    run("fixed21", 40'h2000, 4'd2, 8'd20, 3'd3, 2'b00, 16'h0002, 0, 0);

    // single beat
    push_ar(40'h3000, 4'd0, 4'd3, 3'd3, 2'b01);
    run("single", 40'h3000, 4'd3, 8'd0, 3'd3, 2'b01, 16'h0003, 0, 0);

    // unaligned start, 5-cycle AR stall, rready toggling
    stall_left = 5;
    rready_toggle = 1'b1;
    push_ar(40'h4004, 4'd15, 4'd4, 3'd3, 2'b01);
    push_ar(40'h4080, 4'd15, 4'd4, 3'd3, 2'b01);
    push_ar(40'h4100, 4'd7,  4'd4, 3'd3, 2'b01);
    run("stall", 40'h4004, 4'd4, 8'd39, 3'd3, 2'b01, 16'h0004, 0, 0);
    rready_toggle = 1'b0;
    stall_left = 0;

    // SLVERR at beat 4, DECERR at beat 10
    push_ar(40'h5000, 4'd15, 4'd5, 3'd3, 2'b01);
    push_ar(40'h5080, 4'd15, 4'd5, 3'd3, 2'b01);
    push_ar(40'h5100, 4'd7,  4'd5, 3'd3, 2'b01);
    run("errors", 40'h5000, 4'd5, 8'd39, 3'd3, 2'b01, 16'h0005, 4, 10);

    // legal WRAP forwarded unsplit
    push_ar(40'h8010, 4'd3, 4'd6, 3'd3, 2'b10);
    run("wrap4", 40'h8010, 4'd6, 8'd3, 3'd3, 2'b10, 16'h0006, 0, 0);

    // address wraps at 2^40
    push_ar(40'hFF_FFFF_FFC0, 4'd15, 4'd7, 3'd3, 2'b01);
    push_ar(40'h00_0000_0040, 4'd3,  4'd7, 3'd3, 2'b01);
    run("addr_wrap", 40'hFF_FFFF_FFC0, 4'd7, 8'd19, 3'd3, 2'b01, 16'h0007, 0, 0);

    // reset while in WAIT_R with beats outstanding
    r_hold = 1'b1;
    push_ar(40'h6000, 4'd15, 4'd9, 3'd3, 2'b01);
    push_ar(40'h6080, 4'd15, 4'd9, 3'd3, 2'b01);
    push_ar(40'h6100, 4'd7,  4'd9, 3'd3, 2'b01);
    send_ar(40'h6000, 4'd9, 8'd39, 3'd3, 2'b01);
    cyc = 0;
    while (!(ar_q.size() == 0 && busy && !m_arvalid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_rst_wait_r{busy,m_arvalid}", 64'({busy, m_arvalid}), 64'd2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_m_arvalid", 64'(m_arvalid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_s_arready", 64'(s_arready), 64'd1);
    ar_q.delete();
    r_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r_hold = 1'b0;
    @(negedge clk);
    check("post_rst_s_arready", 64'(s_arready), 64'd1);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_m_arvalid", 64'(m_arvalid), 64'd0);

    push_ar(40'h7000, 4'd7, 4'd8, 3'd2, 2'b01);
    run("after_rst", 40'h7000, 4'd8, 8'd7, 3'd2, 2'b01, 16'h0008, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
